bus_arbiter: RTL

- Shared-bus arbiter that sits directly downstream of the per-PE bus_interface instances.
- Collects each interface's bus_request and returns a one-hot grant, which each bus_interface samples on its grant input.
- Holds the grant until the shared resource (global memory / register file) signals completion, the owner drops its request, or a watchdog expires.
- Uses fair round-robin ordering; the grant_id output steers the bus mux.

---
 rtl/bus_arbiter.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/bus_arbiter.sv
// Round-robin shared-bus arbiter. It grants one bus_interface at a time and holds the
// grant until the shared side completes, the owner abandons, or the watchdog fires.
// Every release is followed by one dead turnaround cycle before arbitration resumes.
module bus_arbiter #(
    parameter int unsigned NUM_PE         = 4,
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned IDW            = $clog2(NUM_PE)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_PE-1:0] bus_request,
    input  logic              txn_done,
    output logic [NUM_PE-1:0] grant,
    output logic              grant_valid,
    output logic [IDW-1:0]    grant_id,
    output logic              timeout_err
);

    // Sized so the counter can reach TIMEOUT_CYCLES-1 without wrapping; one bit when disabled.
    localparam int unsigned    CW       = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam bit             WdogEn   = (TIMEOUT_CYCLES != 0);
    localparam logic [CW-1:0]  CntLimit = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [IDW-1:0] LastPe   = IDW'(NUM_PE - 1);

    typedef enum logic [1:0] {StIdle, StGranted, StRelease} state_e;

    state_e            r_state;
    logic [NUM_PE-1:0] r_grant;
    logic              r_grant_valid;
    logic [IDW-1:0]    r_grant_id;
    logic              r_timeout_err;
    logic [IDW-1:0]    r_rr_ptr;
    logic [CW-1:0]     r_cnt;

    state_e            w_state_d;
    logic [NUM_PE-1:0] w_grant_d;
    logic              w_grant_valid_d;
    logic [IDW-1:0]    w_grant_id_d;
    logic              w_timeout_err_d;
    logic [IDW-1:0]    w_rr_ptr_d;
    logic [CW-1:0]     w_cnt_d;

    logic              w_any_req;
    logic [IDW-1:0]    w_winner;
    logic              w_owner_req;
    logic              w_at_limit;
    logic [IDW-1:0]    w_next_ptr;

    // First set request bit scanning upward from ptr, wrapping modulo NUM_PE.
    // Scanning offsets from high to low lets the smallest offset win without a found flag.
    function automatic logic [IDW-1:0] rr_pick(input logic [NUM_PE-1:0] req,
                                               input logic [IDW-1:0]    ptr);
        logic [IDW-1:0] pick;
        int unsigned    idx;
        pick = '0;
        for (int i = NUM_PE - 1; i >= 0; i--) begin
            idx = (32'(ptr) + 32'(i)) % NUM_PE;
            if (req[IDW'(idx)]) begin
                pick = IDW'(idx);
            end
        end
        return pick;
    endfunction

    assign w_any_req   = |bus_request;
    assign w_winner    = rr_pick(bus_request, r_rr_ptr);
    assign w_owner_req = bus_request[r_grant_id];
    assign w_at_limit  = WdogEn && (r_cnt == CntLimit);
    assign w_next_ptr  = (r_grant_id == LastPe) ? '0 : r_grant_id + 1'b1;

    // Next-state and registered-output values; timeout_err defaults low so it is a pulse.
    always_comb begin
        w_state_d       = r_state;
        w_grant_d       = r_grant;
        w_grant_valid_d = r_grant_valid;
        w_grant_id_d    = r_grant_id;
        w_timeout_err_d = 1'b0;
        w_rr_ptr_d      = r_rr_ptr;
        w_cnt_d         = r_cnt;

        case (r_state)
            StIdle: begin
                if (w_any_req) begin
                    w_state_d       = StGranted;
                    w_grant_d       = NUM_PE'(1) << w_winner;
                    w_grant_valid_d = 1'b1;
                    w_grant_id_d    = w_winner;
                    w_cnt_d         = '0;
                end
            end
            StGranted: begin
                // Completion outranks abandon, which outranks the watchdog.
                if (txn_done || !w_owner_req || w_at_limit) begin
                    w_state_d       = StRelease;
                    w_grant_d       = '0;
                    w_grant_valid_d = 1'b0;
                    w_grant_id_d    = '0;
                    w_rr_ptr_d      = w_next_ptr;
                    w_timeout_err_d = !txn_done && w_owner_req;
                end else if (r_cnt != '1) begin
                    w_cnt_d = r_cnt + 1'b1;
                end
            end
            StRelease: begin
                w_state_d = StIdle;
            end
            default: begin
                w_state_d       = StIdle;
                w_grant_d       = '0;
                w_grant_valid_d = 1'b0;
                w_grant_id_d    = '0;
            end
        endcase
    end

    // State and output registers; reset drops the grant asynchronously.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= StIdle;
            r_grant       <= '0;
            r_grant_valid <= 1'b0;
            r_grant_id    <= '0;
            r_timeout_err <= 1'b0;
            r_rr_ptr      <= '0;
            r_cnt         <= '0;
        end else begin
            r_state       <= w_state_d;
            r_grant       <= w_grant_d;
            r_grant_valid <= w_grant_valid_d;
            r_grant_id    <= w_grant_id_d;
            r_timeout_err <= w_timeout_err_d;
            r_rr_ptr      <= w_rr_ptr_d;
            r_cnt         <= w_cnt_d;
        end
    end

    assign grant       = r_grant;
    assign grant_valid = r_grant_valid;
    assign grant_id    = r_grant_id;
    assign timeout_err = r_timeout_err;

endmodule
